acc_exec_ctrl: RTL

- Execute-stage sequencer that drives the combinational ALU: fetches the register operand, presents accumulator and operand with an opcode select, and captures the result and flags.
- Owns the architectural accumulator and the Z/C flags.
- Sits between the instruction decoder (valid/ready) and the register file (read port, write port).

---
 rtl/acc_exec_ctrl_if.sv | 37 +++
 rtl/acc_exec_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/acc_exec_ctrl_if.sv
// Execute-stage bus bundle: decoder handshake, register-file ports, ALU hookup and architectural state.
// master = controller side, slave = decoder / register file / ALU side.
interface acc_exec_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic [3:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_c;
    logic [DATA_W-1:0] accum;
    logic              z_flag;
    logic              c_flag;
    logic              done;
    logic              illegal;

    modport master (
        input  instr_valid, instr, rf_rdata, alu_result, alu_z, alu_c,
        output instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_sel, alu_a, alu_b, accum, z_flag, c_flag, done, illegal
    );

    modport slave (
        output instr_valid, instr, rf_rdata, alu_result, alu_z, alu_c,
        input  instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_sel, alu_a, alu_b, accum, z_flag, c_flag, done, illegal
    );
endinterface

// File: rtl/acc_exec_ctrl.sv
// Execute-stage sequencer: fetches the register operand, steers the external ALU, owns accum and Z/C.
// Optional build macro ACC_LOCAL_ZERO_EN: Z for ALU ops derived locally from alu_result instead of alu_z.
module acc_exec_ctrl #(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] ACC_RST = '0
) (
    input logic             clk,
    input logic             rst_n,
    acc_exec_ctrl_if.master bus
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned INSTR_W = OP_W + REG_W;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_NOR  = 4'h3;
    localparam logic [OP_W-1:0] OP_MOVR = 4'h4;
    localparam logic [OP_W-1:0] OP_MOVA = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'hB;
    localparam logic [OP_W-1:0] OP_SHR  = 4'hC;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   operand_q;
    logic [DATA_W-1:0]   accum_q;
    logic                z_q, c_q, done_q, illegal_q;
    logic [OP_W-1:0]     op_q;
    logic [OP_W-1:0]     op_in;

    assign op_q  = instr_q[INSTR_W-1:REG_W];
    assign op_in = bus.instr[INSTR_W-1:REG_W];

    function automatic logic needs_fetch(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_NOR, OP_MOVR};
    endfunction

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR};
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return is_alu(op) || (op inside {OP_NOP, OP_MOVR, OP_MOVA});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // rf_we is decoded from state so an asserted reset removes it immediately
    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.alu_sel     = '0;
        bus.rf_we       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_d = needs_fetch(op_in) ? FETCH : EXEC;
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = IDLE;
                if (is_alu(op_q)) bus.alu_sel = op_q;
                bus.rf_we = (op_q == OP_MOVA);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            operand_q <= '0;
            accum_q   <= ACC_RST;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE:  if (bus.instr_valid) instr_q <= bus.instr;
                FETCH: operand_q <= bus.rf_rdata;
                EXEC: begin
                    done_q    <= 1'b1;
                    illegal_q <= !is_legal(op_q);
                    if (is_alu(op_q)) begin
                        accum_q <= bus.alu_result;
                        c_q     <= bus.alu_c;
`ifdef ACC_LOCAL_ZERO_EN
                        z_q     <= (bus.alu_result == '0);
`else
                        z_q     <= bus.alu_z;
`endif
                    end else if (op_q == OP_MOVR) begin
                        accum_q <= operand_q;
                        z_q     <= (operand_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_raddr = instr_q[REG_W-1:0];
    assign bus.rf_waddr = instr_q[REG_W-1:0];
    assign bus.rf_wdata = accum_q;
    assign bus.alu_a    = accum_q;
    assign bus.alu_b    = operand_q;
    assign bus.accum    = accum_q;
    assign bus.z_flag   = z_q;
    assign bus.c_flag   = c_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;
endmodule
